conv_mac_engine: RTL and testbench

//  Parametrised, time-multiplexed KxK convolution MAC for one output channel.
//  - Consumes one input-channel window per handshake beat.
//  - Accumulates IN_CH beats, then rescales by an arithmetic right shift.
//  - Saturates the result to OUT_W bits and presents it on a valid/ready port.
//  - Weights live in an internal RAM written at runtime. Sits between line-buffer/window generator and pooling.

---
 rtl/conv_pkg.sv | 47 ++++
 rtl/conv_tap_mac.sv | 42 ++++
 rtl/conv_mac_engine.sv | 160 ++++++++++++++++
 tb/tb_conv_mac_engine.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the convolution layers: default widths, size helpers and signed saturation.
package conv_pkg;

    localparam int DEF_DATA_W = 12;
    localparam int DEF_WGT_W  = 8;
    localparam int DEF_ACC_W  = 26;
    localparam int DEF_OUT_W  = 14;

    // Working width of the saturation helper; any accumulator up to this width sign-extends into it.
    localparam int SAT_W = 48;

    typedef enum logic [0:0] {
        ST_FILL  = 1'b0,
        ST_DRAIN = 1'b1
    } ctl_state_t;

    function automatic int taps(input int k);
        return k * k;
    endfunction

    // Address/counter width, never below one bit.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Clip v into the signed range of a w-bit value, result still sign-extended to SAT_W.
    function automatic logic signed [SAT_W-1:0] sat_signed(input logic signed [SAT_W-1:0] v,
                                                           input int w);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (SAT_W'(1) <<< (w - 1)) - SAT_W'(1);
        lo = ~hi;
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/conv_tap_mac.sv
// TAPS parallel multipliers with registered products (S1) and the combinational adder tree feeding S2.
module conv_tap_mac
    import conv_pkg::*;
#(
    parameter int TAPS   = 25,
    parameter int DATA_W = DEF_DATA_W,
    parameter int WGT_W  = DEF_WGT_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic                    clk,
    input  logic                    load,
    input  logic [TAPS*DATA_W-1:0]  win,
    input  logic [TAPS*WGT_W-1:0]   wgt,
    output logic [ACC_W-1:0]        sum
);

    localparam int PROD_W = DATA_W + WGT_W;

    logic signed [PROD_W-1:0] prod_r [TAPS];
    logic signed [ACC_W-1:0]  sum_s;

    // S1: capture every tap product of the accepted beat
    always_ff @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < TAPS; i++) begin
                prod_r[i] <= PROD_W'($signed(win[i*DATA_W +: DATA_W]))
                           * PROD_W'($signed(wgt[i*WGT_W +: WGT_W]));
            end
        end
    end

    // Adder tree over the registered products, sign-extended to the accumulator width
    always_comb begin
        sum_s = '0;
        for (int i = 0; i < TAPS; i++) begin
            sum_s = sum_s + ACC_W'(prod_r[i]);
        end
    end

    assign sum = sum_s;

endmodule

// File: rtl/conv_mac_engine.sv
// Time-multiplexed KxK convolution MAC for one output channel with runtime-written weight RAM.
// Optional build macro CONV_RELU_EN clamps negative shifted sums to zero before saturation.
module conv_mac_engine
    import conv_pkg::*;
#(
    parameter int IN_CH  = 3,
    parameter int K      = 5,
    parameter int DATA_W = DEF_DATA_W,
    parameter int WGT_W  = DEF_WGT_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int SHIFT  = 6,
    parameter int OUT_W  = DEF_OUT_W,
    localparam int TAPS   = taps(K),
    localparam int DEPTH  = IN_CH * TAPS,
    localparam int ADDR_W = clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wgt_we,
    input  logic [ADDR_W-1:0]       wgt_addr,
    input  logic [WGT_W-1:0]        wgt_wdata,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [TAPS*DATA_W-1:0]  in_win,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OUT_W-1:0]        out_data,
    output logic                    out_sat
);

    localparam int CH_W = clog2(IN_CH);

    ctl_state_t               state_r, state_nxt;
    logic [CH_W-1:0]          ch_cnt_r, ch_cnt_nxt;
    logic                     accept_s, last_beat_s, idle_s, in_ready_r;
    logic                     s1_valid_r, s1_first_r, s1_last_r;
    logic                     s2_valid_r, s2_last_r;
    logic signed [ACC_W-1:0]  acc_r, tree_sum_s, shifted_s, relu_s;
    logic signed [SAT_W-1:0]  ext_s, clip_s;
    logic                     out_valid_r, out_sat_r;
    logic [OUT_W-1:0]         out_data_r;
    logic [WGT_W-1:0]         wgt_mem [DEPTH];
    logic [TAPS*WGT_W-1:0]    wgt_sel_s;

    assign accept_s = in_valid & in_ready_r;
    assign idle_s   = (state_r == ST_FILL) && (ch_cnt_r == '0) && !s1_valid_r && !s2_valid_r;

    // Weight RAM: not reset; writes outside the idle window are dropped
    always_ff @(posedge clk) begin
        if (wgt_we && idle_s && (int'(wgt_addr) < DEPTH)) begin
            wgt_mem[wgt_addr] <= wgt_wdata;
        end
    end

    // Read the current channel's kernel; a same-edge write is seen only by later beats
    always_comb begin
        wgt_sel_s = '0;
        for (int i = 0; i < TAPS; i++) begin
            wgt_sel_s[i*WGT_W +: WGT_W] = wgt_mem[ADDR_W'(int'(ch_cnt_r) * TAPS + i)];
        end
    end

    conv_tap_mac #(
        .TAPS   (TAPS),
        .DATA_W (DATA_W),
        .WGT_W  (WGT_W),
        .ACC_W  (ACC_W)
    ) u_tap_mac (
        .clk    (clk),
        .load   (accept_s),
        .win    (in_win),
        .wgt    (wgt_sel_s),
        .sum    (tree_sum_s)
    );

    // Next-state: FILL counts beats, DRAIN holds off input until the result is taken
    always_comb begin
        state_nxt   = state_r;
        ch_cnt_nxt  = ch_cnt_r;
        last_beat_s = 1'b0;
        case (state_r)
            ST_FILL: begin
                if (accept_s) begin
                    if (ch_cnt_r == CH_W'(IN_CH - 1)) begin
                        ch_cnt_nxt  = '0;
                        state_nxt   = ST_DRAIN;
                        last_beat_s = 1'b1;
                    end else begin
                        ch_cnt_nxt  = ch_cnt_r + CH_W'(1);
                    end
                end else begin
                    state_nxt = ST_FILL;
                end
            end
            ST_DRAIN: begin
                if (out_valid_r && out_ready) begin
                    state_nxt = ST_FILL;
                end else begin
                    state_nxt = ST_DRAIN;
                end
            end
            default: begin
                state_nxt  = ST_FILL;
                ch_cnt_nxt = '0;
            end
        endcase
    end

    assign shifted_s = acc_r >>> SHIFT;
`ifdef CONV_RELU_EN
    assign relu_s = shifted_s[ACC_W-1] ? '0 : shifted_s;
`else
    assign relu_s = shifted_s;
`endif
    assign ext_s  = SAT_W'(relu_s);
    assign clip_s = sat_signed(ext_s, OUT_W);

    // Control, pipeline valids, accumulator and output register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_FILL;
            ch_cnt_r    <= '0;
            in_ready_r  <= 1'b0;
            s1_valid_r  <= 1'b0;
            s1_first_r  <= 1'b0;
            s1_last_r   <= 1'b0;
            s2_valid_r  <= 1'b0;
            s2_last_r   <= 1'b0;
            acc_r       <= '0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_sat_r   <= 1'b0;
        end else begin
            state_r    <= state_nxt;
            ch_cnt_r   <= ch_cnt_nxt;
            in_ready_r <= (state_nxt == ST_FILL);
            s1_valid_r <= accept_s;
            s1_first_r <= (ch_cnt_r == '0);
            s1_last_r  <= last_beat_s;
            s2_valid_r <= s1_valid_r;
            s2_last_r  <= s1_valid_r & s1_last_r;
            if (s1_valid_r) begin
                acc_r <= s1_first_r ? tree_sum_s : acc_r + tree_sum_s;
            end
            if (s2_valid_r && s2_last_r) begin
                out_valid_r <= 1'b1;
                out_data_r  <= clip_s[OUT_W-1:0];
                out_sat_r   <= (clip_s != ext_s);
            end else if (out_valid_r && out_ready) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_sat   = out_sat_r;

endmodule

// File: tb/tb_conv_mac_engine.sv
// Self-checking bench for conv_mac_engine: vector table, hand-written corner sequences, result scoreboard.
module tb_conv_mac_engine;

    localparam int IN_CH  = 3;
    localparam int TAPS   = 25;
    localparam int DATA_W = 12;
    localparam int OUT_W  = 14;
    localparam int SHIFT  = 6;
    localparam int DEPTH  = IN_CH * TAPS;
    localparam int OUT_MAX = 8191;
    localparam int OUT_MIN = -8192;
    localparam int NVEC   = 8;

    typedef struct {
        int wgt;
        int tap;
        int exp_data;
        bit exp_sat;
    } vec_t;

    typedef struct {
        int data;
        bit sat;
    } exp_t;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   wgt_we = 1'b0;
    logic [6:0]             wgt_addr = '0;
    logic [7:0]             wgt_wdata = '0;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [TAPS*DATA_W-1:0] in_win = '0;
    logic                   out_valid;
    logic                   out_ready = 1'b1;
    logic [OUT_W-1:0]       out_data;
    logic                   out_sat;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_cyc = -100;
    bit   prev_valid = 1'b0;
    exp_t exp_q[$];
    int   wmodel[DEPTH];
    logic [TAPS*DATA_W-1:0] grp[IN_CH];
    vec_t vecs[NVEC];

    always #5 clk = ~clk;

    conv_mac_engine dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wgt_we    (wgt_we),
        .wgt_addr  (wgt_addr),
        .wgt_wdata (wgt_wdata),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_win    (in_win),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input int addr, input int val);
        wgt_we    = 1'b1;
        wgt_addr  = 7'(addr);
        wgt_wdata = 8'(val);
        step();
        wgt_we    = 1'b0;
    endtask

    task automatic fill_weights(input int val);
        for (int a = 0; a < DEPTH; a++) begin
            wr(a, val);
            wmodel[a] = val;
        end
    endtask

    task automatic fill_random_weights();
        int v;
        for (int a = 0; a < DEPTH; a++) begin
            v = int'($urandom_range(0, 255)) - 128;
            wr(a, v);
            wmodel[a] = v;
        end
    endtask

    function automatic logic [TAPS*DATA_W-1:0] flat(input int tap);
        logic [TAPS*DATA_W-1:0] w;
        logic [DATA_W-1:0]      t;
        t = DATA_W'(tap);
        for (int i = 0; i < TAPS; i++) w[i*DATA_W +: DATA_W] = t;
        return w;
    endfunction

    // Reference: full-precision sum, floor shift, optional clamp, clip
    function automatic exp_t model();
        longint s;
        longint sh;
        exp_t   r;
        s = 0;
        for (int c = 0; c < IN_CH; c++)
            for (int i = 0; i < TAPS; i++)
                s += longint'($signed(grp[c][i*DATA_W +: DATA_W])) * longint'(wmodel[c*TAPS+i]);
        sh = s >>> SHIFT;
`ifdef CONV_RELU_EN
        if (sh < 0) sh = 0;
`endif
        r.sat = 1'b0;
        if (sh > OUT_MAX) begin
            sh = OUT_MAX;
            r.sat = 1'b1;
        end else if (sh < OUT_MIN) begin
            sh = OUT_MIN;
            r.sat = 1'b1;
        end
        r.data = int'(sh);
        return r;
    endfunction

    task automatic send_beat(input logic [TAPS*DATA_W-1:0] w);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_win   = w;
        while (!in_ready && n < 60) begin
            step();
            n++;
        end
        if (!in_ready) begin
            check("beat_accept_timeout", 0, 1);
            in_valid = 1'b0;
        end else begin
            step();
            last_cyc = cyc;
        end
    endtask

    task automatic push(input int d, input bit s);
        exp_t e;
        e.data = d;
        e.sat  = s;
        exp_q.push_back(e);
    endtask

    task automatic send_group(input int d, input bit s);
        for (int b = 0; b < IN_CH; b++) send_beat(grp[b]);
        in_valid = 1'b0;
        push(d, s);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            step();
            n++;
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        step();
    endtask

    task automatic set_group(input int tap);
        for (int b = 0; b < IN_CH; b++) grp[b] = flat(tap);
    endtask

    // Scoreboard: latency on each new result, payload compared on each handshake
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (out_valid && !prev_valid) check("latency", cyc - last_cyc, 2);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", int'($signed(out_data)), e.data);
                    check("out_sat", int'(out_sat), int'(e.sat));
                end
            end
        end
        prev_valid = out_valid;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   n;
        vecs[0] = '{1,    64,   75,   1'b0};
        vecs[1] = '{127,  2047, 8191, 1'b1};
`ifdef CONV_RELU_EN
        vecs[2] = '{127,  -2048, 0,   1'b0};
        vecs[3] = '{-1,   100,   0,   1'b0};
`else
        vecs[2] = '{127,  -2048, -8192, 1'b1};
        vecs[3] = '{-1,   100,   -118,  1'b0};
`endif
        vecs[4] = '{2,    1000, 2343, 1'b0};
        vecs[5] = '{-128, -2048, 8191, 1'b1};
        vecs[6] = '{4,    1747, 8189, 1'b0};
        vecs[7] = '{4,    1748, 8191, 1'b1};

        rst_n = 1'b0;
        repeat (3) step();
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_out_sat", int'(out_sat), 0);
        rst_n = 1'b1;
        step();
        check("in_ready_after_rst", int'(in_ready), 1);

        for (int v = 0; v < NVEC; v++) begin
            fill_weights(vecs[v].wgt);
            set_group(vecs[v].tap);
            send_group(vecs[v].exp_data, vecs[v].exp_sat);
            drain();
        end

        // Back-pressure: result held, input blocked, release restores in_ready next cycle
        fill_weights(1);
        out_ready = 1'b0;
        set_group(64);
        send_group(75, 1'b0);
        n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        check("stall_out_valid", int'(out_valid), 1);
        in_valid = 1'b1;
        in_win   = flat(100);
        for (int k = 0; k < 5; k++) begin
            step();
            check("stall_out_data", int'($signed(out_data)), 75);
            check("stall_in_ready", int'(in_ready), 0);
            check("stall_out_valid_held", int'(out_valid), 1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check("in_ready_after_hs", int'(in_ready), 1);
        check("out_valid_after_hs", int'(out_valid), 0);
        drain();

        // Reset in the middle of a group discards it
        set_group(100);
        send_beat(grp[0]);
        send_beat(grp[1]);
        in_valid = 1'b0;
        rst_n = 1'b0;
        step();
        check("mid_rst_in_ready", int'(in_ready), 0);
        rst_n = 1'b1;
        step();
        set_group(64);
        send_group(75, 1'b0);
        drain();

        // Write while mid-group is dropped
        send_beat(grp[0]);
        in_valid = 1'b0;
        wr(0, 2);
        send_beat(grp[1]);
        send_beat(grp[2]);
        in_valid = 1'b0;
        push(75, 1'b0);
        drain();

        // Idle write takes effect for the next group
        wr(0, 2);
        wmodel[0] = 2;
        send_group(76, 1'b0);
        drain();

        // Write coincident with the first beat: that beat still sees the old weight
        wgt_we    = 1'b1;
        wgt_addr  = 7'd0;
        wgt_wdata = 8'd3;
        send_beat(grp[0]);
        wgt_we = 1'b0;
        send_beat(grp[1]);
        send_beat(grp[2]);
        in_valid = 1'b0;
        push(76, 1'b0);
        drain();
        wmodel[0] = 3;
        send_group(77, 1'b0);
        drain();

        // Back-to-back random groups against the reference model
        fill_random_weights();
        for (int g = 0; g < 6; g++) begin
            for (int b = 0; b < IN_CH; b++)
                for (int i = 0; i < TAPS; i++)
                    grp[b][i*DATA_W +: DATA_W] = (g % 2 == 0) ? DATA_W'($urandom_range(0, 4095))
                                                               : DATA_W'(int'($urandom_range(0, 63)) - 32);
            e = model();
            send_group(e.data, e.sat);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
